// File: rtl/mem_pkg.sv
// Shared widths, timing defaults and FSM state encoding for the line responder.
package mem_pkg;

  localparam int ADR_WIDTH_DEF      = 32;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int WORD_OFFSET_DEF    = 2;
  localparam int MEM_DEPTH_LOG2_DEF = 10;
  localparam int LATENCY_DEF        = 4;
  localparam int BEAT_GAP_DEF       = 3;

  // Wide enough for LATENCY and BEAT_GAP up to 15.
  localparam int CNT_W   = 4;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_WB   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] ST_BEAT = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAP  = 3'd4;

  function automatic logic is_refill_state(input logic [STATE_W-1:0] s);
    return (s == ST_WAIT) || (s == ST_BEAT) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Single-port word RAM: synchronous write, registered read. No reset, so
// contents survive a reset of the surrounding logic.
module mem_word_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[adr] <= wdat;
      end else begin
        rdat <= mem[adr];
      end
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Cache line refill responder: critical-word-first burst reads and single-word
// victim writes against a synchronous word RAM.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int ADR_WIDTH      = ADR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int WORD_OFFSET    = WORD_OFFSET_DEF,
  parameter int MEM_DEPTH_LOG2 = MEM_DEPTH_LOG2_DEF,
  parameter int LATENCY        = LATENCY_DEF,
  parameter int BEAT_GAP       = BEAT_GAP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req_i,
  input  logic [ADR_WIDTH-1:0]   mem_adr_i,
  output logic                   mem_ack_o,
  output logic [DATA_WIDTH-1:0]  mem_dat_o,
  output logic [WORD_OFFSET-1:0] mem_word_o,
  input  logic                   wb_req_i,
  input  logic [ADR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]  wb_dat_i,
  output logic                   wb_ack_o,
  output logic                   busy_o,
  output logic [STATE_W-1:0]     dbg_state
);

  // Handshake: requests are levels sampled in IDLE. mem_req_i is held for the
  // whole refill and dropping it aborts; mem_ack_o and wb_ack_o are one-cycle
  // pulses with no backpressure, and data is only meaningful with the pulse.

  localparam int AW = MEM_DEPTH_LOG2;
  localparam int LW = MEM_DEPTH_LOG2 - WORD_OFFSET;
  localparam logic [WORD_OFFSET-1:0] BEAT_LAST = '1;

  logic [STATE_W-1:0]     state;
  logic [CNT_W-1:0]       cnt;
  logic [LW-1:0]          line_q;
  logic [WORD_OFFSET-1:0] word_q;
  logic [WORD_OFFSET-1:0] word_nxt;
  logic [WORD_OFFSET-1:0] beat_q;
  logic [AW-1:0]          wb_wadr_q;
  logic [DATA_WIDTH-1:0]  wb_dat_q;

  logic                   ram_en;
  logic                   ram_we;
  logic [AW-1:0]          ram_adr;
  logic [DATA_WIDTH-1:0]  ram_rdat;

  // Address bits above the backing store alias; byte lanes are not used.
  logic unused_adr;
  assign unused_adr = ^{mem_adr_i, wb_adr_i};

  assign word_nxt = word_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      line_q    <= '0;
      word_q    <= '0;
      beat_q    <= '0;
      wb_wadr_q <= '0;
      wb_dat_q  <= '0;
    end else if (is_refill_state(state) && !mem_req_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          // The victim write wins so a same-line refill sees the new data.
          if (wb_req_i) begin
            state     <= ST_WB;
            wb_wadr_q <= wb_adr_i[AW+1:2];
            wb_dat_q  <= wb_dat_i;
          end else if (mem_req_i) begin
            state  <= ST_WAIT;
            cnt    <= CNT_W'(LATENCY - 1);
            line_q <= mem_adr_i[AW+1:WORD_OFFSET+2];
            word_q <= mem_adr_i[WORD_OFFSET+1:2];
            beat_q <= '0;
          end
        end
        ST_WB: state <= ST_IDLE;
        ST_WAIT, ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_BEAT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_BEAT: begin
          word_q <= word_nxt;
          beat_q <= beat_q + 1'b1;
          if (beat_q == BEAT_LAST) begin
            state <= ST_IDLE;
          end else if (BEAT_GAP == 0) begin
            state <= ST_BEAT;
          end else begin
            state <= ST_GAP;
            cnt   <= CNT_W'(BEAT_GAP - 1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The RAM read is issued in the cycle before each beat so its registered
  // output lines up with mem_ack_o.
  always_comb begin
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_adr = wb_wadr_q;
    case (state)
      ST_WB: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      ST_WAIT, ST_GAP: begin
        if (cnt == '0) begin
          ram_en  = 1'b1;
          ram_adr = {line_q, word_q};
        end
      end
      ST_BEAT: begin
        if ((BEAT_GAP == 0) && (beat_q != BEAT_LAST)) begin
          ram_en  = 1'b1;
          ram_adr = {line_q, word_nxt};
        end
      end
      default: ram_en = 1'b0;
    endcase
  end

  mem_word_ram #(
    .ADDR_W (AW),
    .DATA_W (DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .adr  (ram_adr),
    .wdat (wb_dat_q),
    .rdat (ram_rdat)
  );

  assign mem_ack_o  = (state == ST_BEAT);
  assign mem_dat_o  = mem_ack_o ? ram_rdat : '0;
  assign mem_word_o = mem_ack_o ? word_q : '0;
  assign wb_ack_o   = (state == ST_WB);
  assign busy_o     = (state != ST_IDLE);
  assign dbg_state  = state;

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter WORD_OFFSET, default 2, log2 of words per line (4 beats per refill).
REQ-004 SHALL have parameter MEM_DEPTH_LOG2, default 10, log2 of backing-store words.
REQ-005 SHALL have parameter LATENCY, default 4, cycles from accepted refill to first beat (legal range 2..15).
REQ-006 SHALL have parameter BEAT_GAP, default 3, idle cycles between consecutive beats (legal range 0..15).
REQ-007 SHALL use one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 mem_req_i  in  1  refill request, held by the cache until its last beat.
REQ-011 mem_adr_i  in  ADR_WIDTH  refill byte address; bits [WORD_OFFSET+1:2] give the critical word.
REQ-012 mem_ack_o  out  1  one-cycle beat-valid pulse.
REQ-013 mem_dat_o  out  DATA_WIDTH  beat data, valid only while mem_ack_o=1, else 0.
REQ-014 mem_word_o  out  WORD_OFFSET  word index of the current beat.
REQ-015 wb_req_i  in  1  single-word victim write request.
REQ-016 wb_adr_i  in  ADR_WIDTH  victim byte address.
REQ-017 wb_dat_i  in  DATA_WIDTH  victim data.
REQ-018 wb_ack_o  out  1  one-cycle pulse, write committed.
REQ-019 busy_o  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, WB, WAIT, BEAT, GAP.
REQ-021 In IDLE with wb_req_i=1, SHALL go to WB; in WB it SHALL write wb_dat_i to the backing store, pulse wb_ack_o, and return to IDLE.
REQ-022 In IDLE with wb_req_i=0 and mem_req_i=1, SHALL latch mem_adr_i, load the latency counter, and go to WAIT.
REQ-023 wb_req_i and mem_req_i both high in IDLE: the write SHALL be served first, so a same-line refill returns the written data.
REQ-024 The first mem_ack_o SHALL be asserted exactly LATENCY cycles after the edge that accepts the refill.
REQ-025 Each later beat SHALL follow the previous one after exactly BEAT_GAP idle cycles (BEAT_GAP=0 gives back-to-back beats).
REQ-026 Beat order SHALL be critical-word-first with wrap: start at adr[WORD_OFFSET+1:2] and increment modulo 2^WORD_OFFSET (e.g. 3,0,1,2).
REQ-027 Backing-store word address SHALL be adr[MEM_DEPTH_LOG2+1:2]; upper address bits SHALL be ignored (aliasing).
REQ-028 After the 4th beat, SHALL return to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-029 If mem_req_i falls in WAIT, BEAT or GAP, SHALL abort to IDLE on the next edge with no further acks.
REQ-030 wb_req_i during a refill SHALL be held off until IDLE; wb_ack_o SHALL never coincide with mem_ack_o.
REQ-031 Backing-store reads SHALL be synchronous (one cycle), issued one cycle before the corresponding beat.

Reset
REQ-032 rst=0 SHALL force IDLE and clear the counters and latched address; mem_ack_o, wb_ack_o and busy_o SHALL be 0, and mem_dat_o and mem_word_o SHALL be 0.
REQ-033 Backing-store contents SHALL NOT be altered by reset.
REQ-034 Reset asserted mid-refill SHALL cancel it; no beat SHALL appear after rst is released unless a new request is made.

Structure
REQ-035 Widths, LATENCY/BEAT_GAP defaults and the FSM state encoding SHALL live in a shared package, mem_pkg.
REQ-036 The backing store SHALL be a sub-module, mem_word_ram: single port, synchronous read/write, 2^MEM_DEPTH_LOG2 x DATA_WIDTH.
REQ-037 Implementation SHALL be 120-400 lines of RTL, excluding the package.

Verification
REQ-038 Writes of 32'h1111_0000..32'h1111_0003 to 0x00CC3B40..4C, then refill at 0x00CC3B43 -> 4 acks, words 0,1,2,3, 1st ack at cycle +4, gap 3.
REQ-039 Refill at 0x00CC3B4C -> word order 3,0,1,2 with data 32'h1111_0003, _0000, _0001, _0002.
REQ-040 wb_req_i and mem_req_i together, wb to 0x00CC3B44 with 32'hDEAD_BEEF -> wb_ack_o first; the beat for word 1 returns 32'hDEAD_BEEF.
REQ-041 mem_req_i dropped after the 2nd beat -> IDLE next cycle, no 3rd ack, busy_o=0.
REQ-042 rst pulsed low during WAIT -> all outputs 0 immediately; no ack after release; RAM data intact on re-read.
REQ-043 BEAT_GAP=0, LATENCY=2 -> 4 back-to-back acks, first at cycle +2.
